ram_b_port_ctrl: RTL
====================

# ram_b_port_ctrl

Port controller for the SCAN decoder's per-layer beta storage. It turns layer-level read and write requests from the beta-update unit into beat sequences on the beta RAM's two ports, driving the layer select, beat count and enable on each. It also returns read data through a credit-controlled 4-entry FIFO, so the consumer can apply backpressure despite the RAM's fixed read latency. It sits between the beta-update/PE datapath and the beta RAM.

## Interface
- Q, 6, bits per beta element
- P, 64, elements per read beat; a write beat carries 2P elements
- N, 1024, code length; the largest stored layer is 8, holding 256 elements
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high; clock clk
- req_valid  in  1  layer request valid
- req_ready  out  1  controller idle and able to accept a request
- req_write  in  1  1 = write request, 0 = read request
- req_layer  in  5  target layer, legal range 1..8
- wdata_valid  in  1  write beat valid
- wdata_ready  out  1  write beat accepted this cycle
- wdata  in  2*P*Q  write beat payload
- rdata_valid  out  1  FIFO head valid
- rdata_ready  in  1  consumer pops the FIFO head
- rdata  out  P*Q  FIFO head data
- busy  out  1  state is not IDLE, or read data is in flight or buffered
- err  out  1  sticky illegal-layer flag
- ram_w_en, ram_layer_w[4:0], ram_cnta[3:0], ram_b_in[2*P*Q-1:0]  out  RAM write port, all registered
- ram_r_en, ram_layer_r[4:0], ram_cntb[3:0]  out  RAM read port, all registered
- ram_b_out  in  P*Q  RAM read data, valid 1 cycle after ram_r_en; zero otherwise

## Operation
- Layer L stores 2^L elements.
  - Write beats per request: WB = max(1, 2^L/(2P)). L=8 gives 2, L<=7 gives 1.
  - Read beats per request: RB = max(1, 2^L/P). L=8 gives 4, L=7 gives 2, L<=6 gives 1.
- The beat counter starts at 0 and counts to WB-1 or RB-1. It is driven on ram_cnta or ram_cntb; the RAM applies its own +1 offset internally.
- States:
  - IDLE: req_ready=1. On req_valid & req_ready, latch the layer, clear the beat counter, and go to WR if req_write is 1, otherwise RD.
  - WR: wdata_ready=1. Each wdata_valid & wdata_ready registers one RAM write beat (ram_w_en=1, ram_layer_w=layer, ram_cnta=beat, ram_b_in=wdata) in the next cycle. After beat WB-1, go to IDLE.
  - RD: issue one read beat per cycle while the credit rule allows. After beat RB-1 is issued, go to IDLE.
- Credit rule: a read may issue when fifo_count + inflight - pop < 4.
  - pop = rdata_valid & rdata_ready.
  - inflight = issued beats not yet written into the FIFO (0..2).
- Read data path: ram_b_out is written into the FIFO in the cycle after ram_r_en=1. The FIFO is depth 4, first-word-first-out, and rdata shows the head entry.
- A new request may be accepted while earlier read data is still in flight or buffered. busy stays 1 until the FIFO is empty and inflight = 0.
- In every cycle without a beat, ram_w_en and ram_r_en are 0; layer, count and data outputs hold their last values.
- Read and write ports are never active for the same request. Requests are strictly serialised, so the last write beat reaches the RAM before any later read is issued.

## Timing
- Reset values:
  - req_ready=1, wdata_ready=0, rdata_valid=0, busy=0, err=0.
  - All ram_* outputs are 0; rdata is 0.
  - FIFO and inflight are cleared and state is IDLE.
- rst mid-operation aborts the current request and drops buffered data. No RAM enable is asserted in the cycle after rst.
- Request accepted at edge t: the first write or read issue decision is possible in cycle t+1.
- Write: wdata accepted at edge t drives ram_w_en=1 in cycle t+1.
- Read: issue decision in cycle t gives ram_r_en=1 in cycle t+1, ram_b_out valid in t+2, and rdata_valid in t+3.
- With rdata_ready held at 1, reads stream at 1 beat per cycle. An L=8 read delivers beats 0..3 on rdata in 4 consecutive cycles.
- A FIFO push and pop in the same cycle leave fifo_count unchanged.

## Configuration
- BETA_CTRL_ERR_EN defined:
  - A request with req_layer of 0 or greater than 8 is accepted, performs no RAM access, and returns to IDLE next cycle.
  - err is set and stays 1 until rst.
- BETA_CTRL_ERR_EN undefined:
  - err is tied to 0.
  - An illegal layer is treated as 1 beat and passed to the RAM unchanged, where the RAM ignores it.

## Test plan
- Reset, then write L=8 with two beats A and B back to back: ram_w_en is high for 2 cycles with ram_cnta = 0 then 1, ram_layer_w=8, and ram_b_in = A then B.
- Read L=8 with rdata_ready held at 1 and a RAM model returning the beat index: rdata carries 0, 1, 2, 3 on consecutive cycles starting 4 cycles after acceptance.
- Read L=7 with rdata_ready=0 for 10 cycles: exactly 2 beats are issued, the FIFO holds 2, and busy=1. Raising rdata_ready pops both in order, then busy falls.
- Read L=3: exactly one ram_r_en pulse with ram_cntb=0, and one rdata beat.
- Request with layer 9 when BETA_CTRL_ERR_EN is defined: no ram_w_en or ram_r_en, err=1 from the next cycle, and err still 1 after 100 cycles.
- Assert rst during the third read beat of an L=8 read: all outputs at reset values the next cycle, and no rdata_valid afterwards.

Source files
------------

// File: rtl/ram_b_port_ctrl.sv
// Beta RAM port controller: turns layer requests into write/read beat sequences and buffers
// read data in a credit-controlled 4-entry FIFO. Optional illegal-layer trap: BETA_CTRL_ERR_EN.
module ram_b_port_ctrl #(
  parameter int Q = 6,
  parameter int P = 64,
  parameter int N = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [4:0]         req_layer,
  input  logic               wdata_valid,
  output logic               wdata_ready,
  input  logic [2*P*Q-1:0]   wdata,
  output logic               rdata_valid,
  input  logic               rdata_ready,
  output logic [P*Q-1:0]     rdata,
  output logic               busy,
  output logic               err,
  output logic               ram_w_en,
  output logic [4:0]         ram_layer_w,
  output logic [3:0]         ram_cnta,
  output logic [2*P*Q-1:0]   ram_b_in,
  output logic               ram_r_en,
  output logic [4:0]         ram_layer_r,
  output logic [3:0]         ram_cntb,
  input  logic [P*Q-1:0]     ram_b_out
);

  localparam int DW = P * Q;
  localparam int WW = 2 * P * Q;
  localparam logic [4:0] LAYER_MAX    = 5'($clog2(N) - 2);
  localparam logic [4:0] LAYER_MAX_M1 = LAYER_MAX - 5'd1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  // Last beat index per layer; the top layer spans two write beats and four read beats.
  function automatic logic [1:0] wr_last_f(input logic [4:0] layer);
    logic [1:0] last;
    case (layer)
      LAYER_MAX: last = 2'd1;
      default:   last = 2'd0;
    endcase
    return last;
  endfunction

  function automatic logic [1:0] rd_last_f(input logic [4:0] layer);
    logic [1:0] last;
    case (layer)
      LAYER_MAX:    last = 2'd3;
      LAYER_MAX_M1: last = 2'd1;
      default:      last = 2'd0;
    endcase
    return last;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [4:0]    layer_q, layer_d;
  logic [1:0]    beat_q, beat_d;
  logic          ram_w_en_q, ram_r_en_q, rd_pend_q;
  logic [4:0]    ram_layer_w_q, ram_layer_r_q;
  logic [3:0]    ram_cnta_q, ram_cntb_q;
  logic [WW-1:0] ram_b_in_q;
  logic [DW-1:0] fifo_mem_q [0:3];
  logic [1:0]    fifo_wp_q, fifo_rp_q;
  logic [2:0]    fifo_cnt_q;

  logic       req_fire_s, wr_fire_s, rd_fire_s, push_s, pop_s, credit_ok_s;
  logic [1:0] inflight_s;
  logic [3:0] occupancy_s;

  assign req_fire_s  = req_valid & (state_q == S_IDLE);
  assign wr_fire_s   = wdata_valid & (state_q == S_WR);
  assign push_s      = rd_pend_q;
  assign pop_s       = rdata_valid & rdata_ready;
  // Beats issued but not yet in the FIFO: one at the RAM port, one on ram_b_out.
  assign inflight_s  = {1'b0, ram_r_en_q} + {1'b0, rd_pend_q};
  assign occupancy_s = {1'b0, fifo_cnt_q} + {2'b00, inflight_s};
  assign credit_ok_s = occupancy_s < (4'd4 + {3'b000, pop_s});
  assign rd_fire_s   = credit_ok_s & (state_q == S_RD);

`ifdef BETA_CTRL_ERR_EN
  logic err_q;
  logic layer_ok_s;
  assign layer_ok_s = (req_layer != 5'd0) && (req_layer <= LAYER_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (req_fire_s && !layer_ok_s) begin
      err_q <= 1'b1;
    end else begin
      err_q <= err_q;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    beat_d  = beat_q;
    case (state_q)
      S_IDLE: begin
        if (req_fire_s) begin
          layer_d = req_layer;
          beat_d  = 2'd0;
`ifdef BETA_CTRL_ERR_EN
          if (!layer_ok_s) begin
            state_d = S_ERR;
          end else if (req_write) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
`else
          if (req_write) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR: begin
        if (wr_fire_s) begin
          if (beat_q == wr_last_f(layer_q)) begin
            state_d = S_IDLE;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end else begin
          state_d = S_WR;
        end
      end
      S_RD: begin
        if (rd_fire_s) begin
          if (beat_q == rd_last_f(layer_q)) begin
            state_d = S_IDLE;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end else begin
          state_d = S_RD;
        end
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      layer_q       <= 5'd0;
      beat_q        <= 2'd0;
      ram_w_en_q    <= 1'b0;
      ram_layer_w_q <= 5'd0;
      ram_cnta_q    <= 4'd0;
      ram_b_in_q    <= {WW{1'b0}};
      ram_r_en_q    <= 1'b0;
      ram_layer_r_q <= 5'd0;
      ram_cntb_q    <= 4'd0;
      rd_pend_q     <= 1'b0;
      fifo_wp_q     <= 2'd0;
      fifo_rp_q     <= 2'd0;
      fifo_cnt_q    <= 3'd0;
    end else begin
      state_q    <= state_d;
      layer_q    <= layer_d;
      beat_q     <= beat_d;
      ram_w_en_q <= wr_fire_s;
      ram_r_en_q <= rd_fire_s;
      rd_pend_q  <= ram_r_en_q;
      if (wr_fire_s) begin
        ram_layer_w_q <= layer_q;
        ram_cnta_q    <= {2'b00, beat_q};
        ram_b_in_q    <= wdata;
      end
      if (rd_fire_s) begin
        ram_layer_r_q <= layer_q;
        ram_cntb_q    <= {2'b00, beat_q};
      end
      if (push_s) begin
        fifo_wp_q <= fifo_wp_q + 2'd1;
      end
      if (pop_s) begin
        fifo_rp_q <= fifo_rp_q + 2'd1;
      end
      fifo_cnt_q <= fifo_cnt_q + {2'b00, push_s} - {2'b00, pop_s};
    end
  end

  // FIFO storage needs no reset; rdata is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_q[fifo_wp_q] <= ram_b_out;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign wdata_ready = (state_q == S_WR);
  assign rdata_valid = (fifo_cnt_q != 3'd0);
  assign rdata       = rdata_valid ? fifo_mem_q[fifo_rp_q] : {DW{1'b0}};
  assign busy        = (state_q != S_IDLE) | rdata_valid | (inflight_s != 2'd0);
  assign ram_w_en    = ram_w_en_q;
  assign ram_layer_w = ram_layer_w_q;
  assign ram_cnta    = ram_cnta_q;
  assign ram_b_in    = ram_b_in_q;
  assign ram_r_en    = ram_r_en_q;
  assign ram_layer_r = ram_layer_r_q;
  assign ram_cntb    = ram_cntb_q;

endmodule
